// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage.
// - RESET_PC_DEFAULT : default fetch PC after reset
// - NOP_INSN         : canonical RISC-V nop (addi x0, x0, 0)
// - fetch_state_e    : fetch FSM states
// - fetch_entry_t    : {pc, insn} pair held in the output buffer
// - word_align()     : clears the byte-offset bits of an address
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0100_0000;
  localparam logic [31:0] NOP_INSN         = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t between instruction memory and decode.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   flush           drops all entries (wins over push/pop)
//   push, push_data write one entry
//   pop             retire the head entry
//   head            current head entry (straight from storage)
//   count           number of valid entries
//   full, empty     occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t    mem_r [DEPTH];
  logic [AW-1:0]   rd_ptr_r;
  logic [AW-1:0]   wr_ptr_r;
  logic [CW-1:0]   count_r;

  // Storage, pointers and occupancy; storage is cleared on reset so the
  // head reads as zero until the first push.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= fetch_entry_t'(64'd0);
      end
    end else if (flush) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      count_r <= count_r + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == {CW{1'b0}});

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: holds the PC, issues word-aligned requests to instruction
// memory (one outstanding at most), buffers {pc, insn} pairs and hands them
// to decode over valid/ready. A redirect flushes buffered and in-flight
// fetches.
// Ports:
//   clk, rst                       clock, synchronous active-low reset
//   imem_req_valid_o/ready_i       request handshake
//   imem_addr_o                    word-aligned fetch address
//   imem_rsp_valid_i/data_i        in-order response, >=1 cycle after accept
//   redirect_i, redirect_pc_i      flush strobe and new PC
//   valid_o, ready_i               decode handshake
//   pc_o, insn_o                   presented instruction and its PC
// Build option FETCH_PERF_EN adds perf_fetched_o (buffer pushes) and
// perf_flushed_o (redirects), both wrapping 32-bit counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rsp_valid_i,
  input  logic [31:0] imem_rsp_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] pc_o,
  output logic [31:0] insn_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched_o,
  output logic [31:0] perf_flushed_o
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state_r;
  fetch_state_e  state_s;
  logic [31:0]   fetch_pc_r;
  logic [31:0]   fetch_pc_s;
  logic [31:0]   req_pc_r;
  logic          req_valid_r;
  logic          req_valid_s;
  logic [31:0]   imem_addr_r;
  logic          req_fire_s;
  logic          push_s;
  logic          pop_s;
  logic [CW-1:0] fifo_count_s;
  logic [CW-1:0] count_next_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  fetch_entry_t  push_entry_s;
  fetch_entry_t  head_s;

  // Next-state, strobes and next values of the registered request outputs.
  // The request outputs are computed from next state so they are pure
  // flops yet still allow a request the cycle after a response.
  always_comb begin
    req_fire_s   = req_valid_r & imem_req_ready_i;
    pop_s        = ~fifo_empty_s & ready_i & ~redirect_i;
    push_s       = 1'b0;
    state_s      = state_r;
    fetch_pc_s   = fetch_pc_r;
    push_entry_s = '{pc: req_pc_r, insn: imem_rsp_data_i};

    if (redirect_i) begin
      fetch_pc_s = word_align(redirect_pc_i);
      // Anything still in flight after this edge must be discarded.
      case (state_r)
        REQ:         state_s = req_fire_s ? DRAIN : REQ;
        WAIT, DRAIN: state_s = imem_rsp_valid_i ? REQ : DRAIN;
        default:     state_s = REQ;
      endcase
    end else begin
      case (state_r)
        REQ: begin
          if (req_fire_s) begin
            state_s    = WAIT;
            fetch_pc_s = fetch_pc_r + 32'd4;
          end else begin
            state_s = REQ;
          end
        end
        WAIT: begin
          if (imem_rsp_valid_i) begin
            push_s  = ~fifo_full_s;
            state_s = REQ;
          end else begin
            state_s = WAIT;
          end
        end
        DRAIN: begin
          if (imem_rsp_valid_i) begin
            state_s = REQ;
          end else begin
            state_s = DRAIN;
          end
        end
        default: state_s = REQ;
      endcase
    end

    if (redirect_i) begin
      count_next_s = {CW{1'b0}};
    end else begin
      count_next_s = fifo_count_s + CW'(push_s) - CW'(pop_s);
    end

    // In REQ nothing is outstanding, so one free slot is enough to ask.
    req_valid_s = (state_s == REQ) && (count_next_s < CW'(FIFO_DEPTH));
  end

  // Fetch FSM, PC bookkeeping and registered request outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= REQ;
      fetch_pc_r  <= RESET_PC;
      req_pc_r    <= RESET_PC;
      req_valid_r <= 1'b0;
      imem_addr_r <= RESET_PC;
    end else begin
      state_r     <= state_s;
      fetch_pc_r  <= fetch_pc_s;
      req_valid_r <= req_valid_s;
      imem_addr_r <= fetch_pc_s;
      if (req_fire_s) begin
        req_pc_r <= fetch_pc_r;
      end else begin
        req_pc_r <= req_pc_r;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_i),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .head      (head_s),
    .count     (fifo_count_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign imem_req_valid_o = req_valid_r;
  assign imem_addr_o      = imem_addr_r;
  assign valid_o          = ~fifo_empty_s;
  assign pc_o             = head_s.pc;
  assign insn_o           = head_s.insn;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_r;
  logic [31:0] perf_flushed_r;

  // Event counters for buffered fetches and redirects.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetched_r <= 32'd0;
      perf_flushed_r <= 32'd0;
    end else begin
      perf_fetched_r <= perf_fetched_r + {31'd0, push_s};
      perf_flushed_r <= perf_flushed_r + {31'd0, redirect_i};
    end
  end

  assign perf_fetched_o = perf_fetched_r;
  assign perf_flushed_o = perf_flushed_r;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i = 1'b0;
  logic [31:0] imem_addr_o;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_data_i = 32'd0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'd0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] pc_o;
  logic [31:0] insn_o;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_o;
  logic [31:0] perf_flushed_o;
`endif

  fetch_stage dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_addr_o      (imem_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .valid_o          (valid_o),
    .ready_i          (ready_i),
    .pc_o             (pc_o),
    .insn_o           (insn_o)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched_o   (perf_fetched_o),
    .perf_flushed_o   (perf_flushed_o)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_pops  = 0;
  int n_push  = 0;
  int n_redir = 0;

  // Stimulus knobs.
  int          mem_rdy = 100;
  int          dec_rdy = 100;
  int          lat_min = 0;
  int          lat_max = 0;
  int          redir_pct = 0;
  bit          redir_now = 1'b0;
  logic [31:0] redir_tgt = 32'd0;
  bit          rst_now = 1'b0;
  bit          coin_arm = 1'b0;
  bit          coin_done = 1'b0;
  bit          fired = 1'b0;
  logic [31:0] fire_addr = 32'd0;

  // Memory model and scoreboard state.
  bit          m_out = 1'b0;
  bit          m_taint = 1'b0;
  logic [31:0] m_addr = 32'd0;
  int          m_lat = 0;
  logic [31:0] req_exp_addr = RST_PC;
  logic [63:0] sb_q[$];

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return ((a - RST_PC) * 32'h9E37_79B1) ^ 32'h0050_0193;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: choose inputs for the coming edge and update the
  // reference model with what that edge will do.
  task automatic step();
    logic fire;
    @(posedge clk);
    #1;
    rst              = rst_now ? 1'b0 : 1'b1;
    imem_req_ready_i = ($urandom_range(99) < mem_rdy);
    ready_i          = ($urandom_range(99) < dec_rdy);
    if (m_out && (m_lat == 0 || rst_now)) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = mem_fn(m_addr);
    end else begin
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = NOP_INSN;
    end
    redirect_i    = redir_now || ($urandom_range(99) < redir_pct);
    redirect_pc_i = redir_now ? redir_tgt : $urandom;
    if (coin_arm && imem_rsp_valid_i && valid_o) begin
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h0300_0000;
      ready_i       = 1'b1;
      coin_arm      = 1'b0;
      coin_done     = 1'b1;
    end
    fire = 1'b0;
    if (rst_now) begin
      m_out = 1'b0;
      sb_q.delete();
      req_exp_addr = RST_PC;
      n_push  = 0;
      n_redir = 0;
    end else begin
      fire = imem_req_valid_o && imem_req_ready_i;
      if (fire) chk("single_outstanding", {63'd0, m_out}, 64'd0);
      if (imem_rsp_valid_i) begin
        if (!m_taint && !redirect_i) begin
          sb_q.push_back({m_addr, imem_rsp_data_i});
          n_push++;
        end
        m_out = 1'b0;
      end
      if (fire) begin
        chk("req_addr", {32'd0, imem_addr_o}, {32'd0, req_exp_addr});
        fire_addr    = imem_addr_o;
        req_exp_addr = req_exp_addr + 32'd4;
        m_out   = 1'b1;
        m_addr  = imem_addr_o;
        m_lat   = $urandom_range(lat_max, lat_min);
        m_taint = redirect_i;
      end else if (m_out && m_lat != 0) begin
        m_lat--;
      end
      if (redirect_i) begin
        if (m_out) m_taint = 1'b1;
        sb_q.delete();
        req_exp_addr = word_align(redirect_pc_i);
        n_redir++;
      end
    end
    fired = fire;
  endtask

  // Monitor: retires decode handshakes against the scoreboard and checks
  // PC continuity, hold-while-stalled and post-flush emptiness.
  initial begin
    logic [31:0] exp_pc;
    logic [31:0] prev_pc;
    logic [31:0] prev_insn;
    logic [63:0] e;
    bit          prev_redir;
    bit          prev_stall;
    exp_pc = RST_PC; prev_pc = 32'd0; prev_insn = 32'd0;
    prev_redir = 1'b0; prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        exp_pc = RST_PC; prev_redir = 1'b0; prev_stall = 1'b0;
      end else begin
        if (prev_redir) chk("post_redirect_valid", {63'd0, valid_o}, 64'd0);
        if (prev_stall) chk("stall_hold", {31'd0, valid_o, pc_o}, {31'd0, 1'b1, prev_pc});
        if (prev_stall) chk("stall_hold_insn", {32'd0, insn_o}, {32'd0, prev_insn});
        if (valid_o && ready_i && !redirect_i) begin
          chk("sb_nonempty", {63'd0, (sb_q.size() != 0)}, 64'd1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("sb_entry", {pc_o, insn_o}, e);
          end
          chk("pc_sequence", {32'd0, pc_o}, {32'd0, exp_pc});
          exp_pc = exp_pc + 32'd4;
          n_pops++;
        end
        prev_stall = valid_o && !ready_i && !redirect_i;
        prev_pc    = pc_o;
        prev_insn  = insn_o;
        prev_redir = redirect_i;
        if (redirect_i) exp_pc = word_align(redirect_pc_i);
      end
    end
  end

  initial begin
    int pops0;
    // Reset state.
    rst_now = 1'b1; step();
    rst_now = 1'b0; step();
    chk("rst_valid", {63'd0, valid_o}, 64'd0);
    chk("rst_req_valid", {63'd0, imem_req_valid_o}, 64'd0);
    chk("rst_pc", {32'd0, pc_o}, 64'd0);
    chk("rst_insn", {32'd0, insn_o}, 64'd0);
    chk("rst_addr", {32'd0, imem_addr_o}, {32'd0, RST_PC});
`ifdef FETCH_PERF_EN
    chk("rst_perf", {perf_fetched_o, perf_flushed_o}, 64'd0);
`endif

    // First fetch latency with a single-cycle memory.
    fired = 1'b0;
    for (int i = 0; i < 10 && !fired; i++) step();
    chk("first_fire_seen", {63'd0, fired}, 64'd1);
    chk("first_fire_addr", {32'd0, fire_addr}, {32'd0, RST_PC});
    step();
    chk("lat_valid_n1", {63'd0, valid_o}, 64'd0);
    step();
    chk("lat_valid_n2", {63'd0, valid_o}, 64'd1);
    chk("lat_first_entry", {pc_o, insn_o}, {RST_PC, 32'h0050_0193});

    // Decode stall fills the buffer and gates requests.
    dec_rdy = 0;
    for (int i = 0; i < 10; i++) step();
    chk("stall_req_gated", {63'd0, imem_req_valid_o}, 64'd0);
    chk("stall_valid", {63'd0, valid_o}, 64'd1);
    chk("stall_head_pc", {32'd0, pc_o}, {32'd0, 32'h0100_0004});
    dec_rdy = 100;
    pops0 = n_pops;
    for (int i = 0; i < 12; i++) step();
    chk("unstall_delivered", {63'd0, (n_pops - pops0 >= 3)}, 64'd1);

    // Redirect while waiting on memory.
    lat_min = 3; lat_max = 3;
    fired = 1'b0;
    for (int i = 0; i < 20 && !fired; i++) step();
    chk("wait_fire_seen", {63'd0, fired}, 64'd1);
    redir_now = 1'b1; redir_tgt = 32'h0200_0010; step(); redir_now = 1'b0;
    fired = 1'b0;
    for (int i = 0; i < 20 && !fired; i++) step();
    chk("redir_fire_addr", {31'd0, fired, fire_addr}, {31'd0, 1'b1, 32'h0200_0010});
    for (int i = 0; i < 30 && valid_o !== 1'b1; i++) step();
    chk("redir_first_pc", {31'd0, valid_o, pc_o}, {31'd0, 1'b1, 32'h0200_0010});

    // Misaligned redirect target.
    lat_min = 0; lat_max = 0;
    redir_now = 1'b1; redir_tgt = 32'h0200_0013; step(); redir_now = 1'b0;
    step();
    chk("misaligned_addr", {32'd0, imem_addr_o}, {32'd0, 32'h0200_0010});

    // Redirect coincident with a response and a decode pop.
    dec_rdy = 0; coin_done = 1'b0; coin_arm = 1'b1;
    for (int i = 0; i < 20 && !coin_done; i++) step();
    chk("coin_seen", {63'd0, coin_done}, 64'd1);
    coin_arm = 1'b0; dec_rdy = 100;
    step();
    chk("coin_empty_1", {63'd0, valid_o}, 64'd0);
    step();
    chk("coin_empty_2", {63'd0, valid_o}, 64'd0);

    // One-cycle reset in WAIT while memory answers.
    lat_min = 3; lat_max = 3;
    fired = 1'b0;
    for (int i = 0; i < 20 && !fired; i++) step();
    chk("rst_wait_fire_seen", {63'd0, fired}, 64'd1);
    rst_now = 1'b1; step(); rst_now = 1'b0;
    lat_min = 0; lat_max = 0;
    step();
    chk("midrst_valid", {63'd0, valid_o}, 64'd0);
    chk("midrst_req_valid", {63'd0, imem_req_valid_o}, 64'd0);
    chk("midrst_addr", {32'd0, imem_addr_o}, {32'd0, RST_PC});
`ifdef FETCH_PERF_EN
    chk("midrst_perf", {perf_fetched_o, perf_flushed_o}, 64'd0);
`endif
    fired = 1'b0;
    for (int i = 0; i < 10 && !fired; i++) step();
    chk("midrst_fire_addr", {31'd0, fired, fire_addr}, {31'd0, 1'b1, RST_PC});

    // Randomized traffic.
    for (int c = 0; c < 8; c++) begin
      mem_rdy   = $urandom_range(100, 50);
      dec_rdy   = $urandom_range(100, 30);
      lat_max   = $urandom_range(3, 0);
      lat_min   = 0;
      redir_pct = $urandom_range(8, 0);
      for (int i = 0; i < 300; i++) step();
    end

    // Drain: no new requests, decode always ready.
    redir_pct = 0; mem_rdy = 0; dec_rdy = 100; lat_max = 0;
    for (int i = 0; i < 30; i++) step();
    chk("sb_drained", {32'd0, 32'(sb_q.size())}, 64'd0);
    @(posedge clk);
    #1;
    redirect_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
`ifdef FETCH_PERF_EN
    chk("perf_fetched", {32'd0, perf_fetched_o}, {32'd0, 32'(n_push)});
    chk("perf_flushed", {32'd0, perf_flushed_o}, {32'd0, 32'(n_redir)});
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Pipeline stage directly upstream of decode.
- Holds the PC and issues word-aligned requests to instruction memory over a valid/ready handshake.
- Buffers returned instructions with their PCs in a small FIFO.
- Presents {pc, insn} to decode with valid/ready flow control.
- Supports a redirect (branch/jump) that flushes buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h01000000, PC loaded on reset.
- FIFO_DEPTH, 2, entries in the output buffer (power of 2, ≥2).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-low reset (asserted when 0, sampled on posedge clk).
- imem_req_valid_o  output  1  fetch request valid.
- imem_req_ready_i  input  1  memory accepts request.
- imem_addr_o  output  32  fetch address (word-aligned).
- imem_rsp_valid_i  input  1  response valid.
- imem_rsp_data_i  input  32  instruction word.
- redirect_i  input  1  redirect/flush strobe from execute.
- redirect_pc_i  input  32  new fetch PC.
- valid_o  output  1  {pc_o, insn_o} valid to decode.
- ready_i  input  1  decode accepts.
- pc_o  output  32  PC of the presented instruction.
- insn_o  output  32  presented instruction.

Behaviour:
- Reset (rst==0 at posedge):
  - fetch_pc=RESET_PC, FIFO empty, FSM=REQ.
  - valid_o=0, imem_req_valid_o=0, pc_o=0, insn_o=0, imem_addr_o=RESET_PC.
  - Any outstanding response is forgotten; a response arriving during reset is ignored.
  - A reset asserted mid-transaction wins over all other events.
- At most one outstanding request. Memory returns responses in order, ≥1 cycle after acceptance.
- FSM states:
  - REQ: imem_req_valid_o=1 only if FIFO free slots minus outstanding ≥1; imem_addr_o=fetch_pc. On req&ready: latch req_pc=fetch_pc, fetch_pc+=4 (32-bit wrap, 0xFFFFFFFC→0), go WAIT.
  - WAIT: on imem_rsp_valid_i, push {req_pc, data} into FIFO, go REQ. Back-to-back is allowed: the new request is issued the cycle after the response.
  - DRAIN: entered on redirect while WAIT. Discard the next response (no push), then go REQ.
- Redirect (highest priority after reset):
  - Same cycle: FIFO cleared, fetch_pc=redirect_pc_i with bits[1:0] forced to 0.
  - valid_o=0 the following cycle.
  - Redirect in REQ with req&ready the same cycle: the request counts as outstanding; go DRAIN.
  - Redirect in WAIT with rsp_valid the same cycle: the response is dropped; go REQ.
  - A decode pop in the redirect cycle is ignored (the flush wins).
- Output:
  - valid_o = FIFO not empty; pc_o/insn_o = FIFO head (registered storage, no combinational path from imem_rsp).
  - Pop on valid_o&ready_i.
  - Simultaneous push and pop when full is never possible: the request gating guarantees a slot.
  - Push and pop in the same cycle keep the count unchanged.
- Latency: request accepted at cycle N with response at N+1 → valid_o at N+2.
- Throughput: one instruction per 2 cycles with single-cycle memory. Stalled decode (ready_i=0) holds pc_o/insn_o stable.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - Output perf_fetched_o[31:0] counts FIFO pushes.
  - Output perf_flushed_o[31:0] counts redirects.
  - Both reset to 0, wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package: RESET_PC default constant, NOP_INSN=32'h00000013, fetch FSM state enum {REQ, WAIT, DRAIN}, and a packed struct fetch_entry_t {pc[31:0], insn[31:0]}.
- One sub-module, fetch_fifo: synchronous FIFO of fetch_entry_t with push/pop/flush, count, full/empty.

Test Plan:
- Reset with RESET_PC=0x01000000, memory always ready, 1-cycle latency returning 0x00500193 → first request addr 0x01000000, valid_o rises at cycle 2, pc_o=0x01000000, insn_o=0x00500193; next request addr 0x01000004.
- ready_i=0 for 10 cycles → FIFO fills to 2, no further imem_req_valid_o, pc_o/insn_o stable. Then ready_i=1 → PCs 0x01000000, 0x01000004, 0x01000008 delivered in order, none lost or duplicated.
- Redirect to 0x02000010 while in WAIT → that response is discarded, next request addr 0x02000010, next valid pc_o=0x02000010.
- Redirect to 0x02000013 (misaligned) → imem_addr_o=0x02000010.
- redirect_i coincident with imem_rsp_valid_i and with valid_o&ready_i → no push, no stale output, FIFO empty the next cycle.
- rst=0 for one cycle mid-WAIT, memory responds during reset → response ignored, next request addr 0x01000000; with FETCH_PERF_EN, counters read 0.
